// File: rtl/hpt_scenario_sequencer.sv
// rtl/hpt_scenario_sequencer.sv - HPT-axis demo scenario sequencer and display mux
//
// Purpose:
//   Runs one disease cycle per scenario, either hyperthyroid or hypothyroid.
//   The sequence is: trigger the cycle, wait for it to reach treatment-wait,
//   apply treatment (timed auto or manual key), then wait for it to return
//   to normal. The active cycle's data bus and image one-hot are muxed onto
//   the shared display outputs.
//   Both cycles encode their state in data[7:5]: 3'b000 is normal and
//   3'b110 is treatment-wait.
//
// Ports:
//   clk, resetn        clock; asynchronous active-low reset
//   start              level input; a rising edge starts a scenario
//   mode_sel[1:0]      01 = hyper, 10 = hypo, other values are ignored
//   auto_en            1 = timed treatment, 0 = manual key (sampled on reaching treatment-wait)
//   manual_treat       level input; a rising edge applies treatment in manual mode
//   data_*/image_*     cycle data bus and image one-hot from each cycle
//   trig_*/treat_*     trigger and treatment strobes to each cycle
//   data_out/image_out registered display mux output (1-cycle latency)
//   active_sel[1:0]    latched mode, 00 when idle
//   busy               scenario in progress
//   done               one-cycle pulse at scenario completion
//   err                sticky watchdog error, cleared by the next valid start

module hpt_scenario_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int DWELL    = 3,
    parameter int WDOG     = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] mode_sel,
    input  logic       auto_en,
    input  logic       manual_treat,
    input  logic [7:0] data_hyper,
    input  logic [9:0] image_hyper,
    input  logic [7:0] data_hypo,
    input  logic [9:0] image_hypo,
    output logic       trig_hyper,
    output logic       treat_hyper,
    output logic       trig_hypo,
    output logic       treat_hypo,
    output logic [7:0] data_out,
    output logic [9:0] image_out,
    output logic [1:0] active_sel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] ST_NORMAL = 3'b000;
    localparam logic [2:0] ST_TWAIT  = 3'b110;
    localparam logic [1:0] SEL_NONE  = 2'b00;
    localparam logic [1:0] SEL_HYPER = 2'b01;
    localparam logic [1:0] SEL_HYPO  = 2'b10;
    localparam logic [9:0] IMG_HEALTHY = 10'b0000000001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DWELL,
        S_WAITKEY,
        S_TREAT,
        S_RECOVER,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_tick_cnt;
    logic [31:0] r_dwell_cnt;
    logic [31:0] r_wdog_cnt;
    logic        r_start_low;
    logic        r_manual_low;
    logic [1:0]  r_active_sel;
    logic        r_err;
    logic [7:0]  r_data_out;
    logic [9:0]  r_image_out;

    logic        w_tick;
    logic        w_start_rise;
    logic        w_manual_rise;
    logic        w_mode_valid;
    logic [2:0]  w_sst;
    logic        w_start_ok;
    logic        w_wdog_expire;

    // Free-running tick generator; the tick is high in the last count so it
    // is sampled on the edge where the counter wraps.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 32'd1;
        end
    end

    assign w_tick = (r_tick_cnt == 32'(TICK_DIV - 1));

    // The edge detectors remember "input was seen low". They reset to 0, so
    // an input held high through reset must first drop before it can
    // register a rising edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_start_low  <= 1'b0;
            r_manual_low <= 1'b0;
        end else begin
            r_start_low  <= ~start;
            r_manual_low <= ~manual_treat;
        end
    end

    assign w_start_rise  = start & r_start_low;
    assign w_manual_rise = manual_treat & r_manual_low;
    assign w_mode_valid  = (mode_sel == SEL_HYPER) || (mode_sel == SEL_HYPO);

    always_comb begin
        w_sst = ST_NORMAL;
        case (r_active_sel)
            SEL_HYPER: w_sst = data_hyper[7:5];
            SEL_HYPO:  w_sst = data_hypo[7:5];
            default:   w_sst = ST_NORMAL;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next        = r_state;
        w_start_ok    = 1'b0;
        w_wdog_expire = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_rise && w_mode_valid) begin
                    w_start_ok = 1'b1;
                    w_next     = S_ARM;
                end
            end
            S_ARM: begin
                // A cycle that has left normal wins over a same-cycle timeout.
                if (w_sst != ST_NORMAL) begin
                    w_next = S_RUN;
                end else if (w_tick && (r_wdog_cnt == 32'(WDOG - 1))) begin
                    w_wdog_expire = 1'b1;
                    w_next        = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_sst == ST_TWAIT) begin
                    w_next = auto_en ? S_DWELL : S_WAITKEY;
                end
            end
            S_DWELL: begin
                if (w_tick && (r_dwell_cnt == 32'(DWELL - 1))) begin
                    w_next = S_TREAT;
                end
            end
            S_WAITKEY: begin
                if (w_manual_rise) begin
                    w_next = S_TREAT;
                end
            end
            S_TREAT: begin
                if (w_sst != ST_TWAIT) begin
                    w_next = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (w_sst == ST_NORMAL) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Dwell and watchdog counters sit at zero outside their own state, so
    // each entry starts from zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dwell_cnt <= '0;
            r_wdog_cnt  <= '0;
        end else begin
            if (r_state != S_DWELL) begin
                r_dwell_cnt <= '0;
            end else if (w_tick) begin
                r_dwell_cnt <= r_dwell_cnt + 32'd1;
            end

            if (r_state != S_ARM) begin
                r_wdog_cnt <= '0;
            end else if (w_tick) begin
                r_wdog_cnt <= r_wdog_cnt + 32'd1;
            end
        end
    end

    // Latched mode and sticky error flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_active_sel <= SEL_NONE;
            r_err        <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_active_sel <= mode_sel;
                r_err        <= 1'b0;
            end else if (w_wdog_expire) begin
                r_active_sel <= SEL_NONE;
                r_err        <= 1'b1;
            end else if (r_state == S_DONE) begin
                r_active_sel <= SEL_NONE;
            end
        end
    end

    // Registered display mux
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data_out  <= '0;
            r_image_out <= IMG_HEALTHY;
        end else begin
            case (r_active_sel)
                SEL_HYPER: begin
                    r_data_out  <= data_hyper;
                    r_image_out <= image_hyper;
                end
                SEL_HYPO: begin
                    r_data_out  <= data_hypo;
                    r_image_out <= image_hypo;
                end
                default: begin
                    r_data_out  <= '0;
                    r_image_out <= IMG_HEALTHY;
                end
            endcase
        end
    end

    // Strobes are decoded from state so that reset clears them immediately.
    // Qualifying with the latched mode keeps the unselected cycle quiet.
    assign trig_hyper  = (r_state == S_ARM)   && (r_active_sel == SEL_HYPER);
    assign trig_hypo   = (r_state == S_ARM)   && (r_active_sel == SEL_HYPO);
    assign treat_hyper = (r_state == S_TREAT) && (r_active_sel == SEL_HYPER);
    assign treat_hypo  = (r_state == S_TREAT) && (r_active_sel == SEL_HYPO);

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign err        = r_err;
    assign active_sel = r_active_sel;
    assign data_out   = r_data_out;
    assign image_out  = r_image_out;

endmodule
